// File: rtl/output_uart_tx.sv
// ---------------------------------------------------------------------------
// output_uart_tx
// Byte-wide CPU output port that serialises bytes onto a UART line (8N1,
// LSB first, idle high). Writes are buffered in a 4-entry FIFO so the CPU
// can issue several OUT instructions without waiting for the line.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high reset
//   data_in    : byte to send, sampled when tx_en is high
//   tx_en      : one-cycle write strobe
//   tx         : registered serial output
//   busy       : frame in progress or bytes still queued
//   fifo_count : bytes queued but not yet started (0..4)
//   overflow   : sticky, a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module output_uart_tx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       tx_en,
  output logic       tx,
  output logic       busy,
  output logic [2:0] fifo_count,
  output logic       overflow
);

  localparam int DATA_W = 8;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_MAX = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [BAUD_W-1:0]   baud, baud_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [2:0]          bit_idx_inc;
  logic                tx_q, tx_n;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   mem [4];
  logic [1:0]          wr_ptr, rd_ptr;
  logic [2:0]          count;
  logic                overflow_q;
  logic                pop, push, baud_end;

  assign baud_end    = (baud == BAUD_MAX);
  assign bit_idx_inc = bit_idx + 3'd1;

  // A full FIFO can still accept when the head leaves on the same edge.
  assign push = tx_en && ((count != 3'd4) || pop);

  // Next-state and next-line-level logic; tx_n is the level the line takes
  // after the edge, so the output stays a plain flop.
  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    tx_n      = tx_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n = 1'b1;
        if (count != 3'd0) begin
          pop     = 1'b1;
          state_n = START;
          baud_n  = '0;
          tx_n    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          state_n   = DATA;
          baud_n    = '0;
          bit_idx_n = 3'd0;
          tx_n      = shreg[0];
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
            tx_n    = 1'b1;
          end else begin
            bit_idx_n = bit_idx_inc;
            tx_n      = shreg[bit_idx_inc];
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          // Chain straight into the next start bit when more data waits.
          if (count != 3'd0) begin
            pop     = 1'b1;
            state_n = START;
            tx_n    = 1'b0;
          end else begin
            state_n = IDLE;
            tx_n    = 1'b1;
          end
        end else begin
          baud_n = baud + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        tx_n    = 1'b1;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= 3'd0;
      tx_q       <= 1'b1;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      overflow_q <= 1'b0;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      tx_q    <= tx_n;
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
      if (tx_en && !push) overflow_q <= 1'b1;
    end
  end

  // Data storage: FIFO entries and the frame shift register need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
    if (pop)  shreg <= mem[rd_ptr];
  end

  assign tx         = tx_q;
  assign busy       = (state != IDLE) || (count != 3'd0);
  assign fifo_count = count;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_output_uart_tx.sv
module tb_output_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 10 * N;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       tx_en;
  logic       tx;
  logic       busy;
  logic [2:0] fifo_count;
  logic       overflow;

  int n_tests = 0;
  int n_fail  = 0;

  output_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .tx_en(tx_en),
    .tx(tx), .busy(busy), .fifo_count(fifo_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Reference model: queue of waiting bytes plus the byte on the wire and
  // how many cycles of its 10-bit frame remain.
  logic [7:0] m_q[$];
  bit         m_infl;
  int         m_rem;
  logic [7:0] m_cur;
  bit         m_ovf;

  function automatic void m_reset();
    m_q.delete();
    m_infl = 0;
    m_rem  = 0;
    m_cur  = 8'h00;
    m_ovf  = 0;
  endfunction

  function automatic void m_edge(input bit en, input logic [7:0] d);
    bit frame_end, do_pop, acc;
    frame_end = m_infl && (m_rem == 1);
    do_pop    = (m_q.size() > 0) && (!m_infl || frame_end);
    acc       = en && ((m_q.size() < 4) || do_pop);
    if (do_pop) begin
      m_cur  = m_q.pop_front();
      m_infl = 1;
      m_rem  = FRAME;
    end else if (frame_end) begin
      m_infl = 0;
    end else if (m_infl) begin
      m_rem--;
    end
    if (en) begin
      if (acc) m_q.push_back(d);
      else     m_ovf = 1;
    end
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_infl) return 1'b1;
    k = (FRAME - m_rem) / N;
    if (k == 0) return 1'b0;
    if (k == 9) return 1'b1;
    return m_cur[k-1];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tx"}, {7'd0, tx}, {7'd0, m_tx()});
    check({tag, ".busy"}, {7'd0, busy}, {7'd0, (m_infl || m_q.size() > 0)});
    check({tag, ".count"}, {5'd0, fifo_count}, 8'(m_q.size()));
    check({tag, ".ovf"}, {7'd0, overflow}, {7'd0, m_ovf});
  endtask

  // One clock: drive inputs, step model on the edge, check 1 time unit later.
  task automatic tick(input bit en, input logic [7:0] d, input string tag);
    tx_en   = en;
    data_in = d;
    @(posedge clk);
    if (reset) m_reset();
    else       m_edge(en, d);
    #1;
    check_all(tag);
    tx_en = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while ((m_infl || m_q.size() > 0) && guard < 1000) begin
      tick(0, 8'h00, tag);
      guard++;
    end
    tick(0, 8'h00, tag);
    check({tag, ".drained"}, {7'd0, busy}, 8'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    tick(0, 8'h00, "rst");
    tick(0, 8'h00, "rst");
    #2 reset = 1'b0;
  endtask

  initial begin
    logic [9:0] pat;
    logic [7:0] line [40];
    int         peak, guard;
    bit         busy_gap;
    logic [7:0] d;

    reset   = 1'b1;
    tx_en   = 1'b0;
    data_in = 8'h00;
    m_reset();
    #3;
    check("reset.tx", {7'd0, tx}, 8'd1);
    check("reset.busy", {7'd0, busy}, 8'd0);
    check("reset.count", {5'd0, fifo_count}, 8'd0);
    check("reset.ovf", {7'd0, overflow}, 8'd0);
    tick(0, 8'h00, "rst");
    #2 reset = 1'b0;
    tick(0, 8'h00, "idle");

    // Single byte 0xA5: line must read start, 1,0,1,0,0,1,0,1, stop.
    pat = 10'b1101001010;
    tick(1, 8'hA5, "single.push");
    check("single.tx_still_high", {7'd0, tx}, 8'd1);
    for (int i = 0; i < 40; i++) begin
      tick(0, 8'h00, "single");
      line[i] = {7'd0, tx};
    end
    for (int b = 0; b < 10; b++)
      for (int j = 0; j < N; j++)
        check($sformatf("single.bit%0d", b), line[b*N+j], {7'd0, pat[b]});
    tick(0, 8'h00, "single.end");
    check("single.busy_drop", {7'd0, busy}, 8'd0);

    // Back-to-back: three contiguous frames, queue peaks at 2.
    peak = 0;
    busy_gap = 0;
    for (int i = 1; i <= 3; i++) begin
      tick(1, 8'(i), "b2b.push");
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
    for (int i = 0; i < 3 * FRAME - 3; i++) begin
      tick(0, 8'h00, "b2b");
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (!busy) busy_gap = 1;
    end
    check("b2b.peak", 8'(peak), 8'd2);
    check("b2b.no_gap", {7'd0, busy_gap}, 8'd0);
    drain("b2b.drain");

    // Overflow: six consecutive pushes, the last is dropped.
    for (int i = 0; i < 6; i++) tick(1, 8'h30 + 8'(i), "ovf.push");
    check("ovf.flag", {7'd0, overflow}, 8'd1);
    check("ovf.count", {5'd0, fifo_count}, 8'd4);
    drain("ovf.drain");
    check("ovf.sticky", {7'd0, overflow}, 8'd1);

    // Full FIFO accepts a push on the same edge as the STOP->START pop.
    do_reset();
    for (int i = 0; i < 5; i++) tick(1, 8'h50 + 8'(i), "full.push");
    guard = 0;
    while (!(m_infl && m_rem == 1) && guard < 100) begin
      tick(0, 8'h00, "full.wait");
      guard++;
    end
    check("full.wait_bound", 8'(guard < 100), 8'd1);
    tick(1, 8'h5F, "full.simul");
    check("full.count_kept", {5'd0, fifo_count}, 8'd4);
    check("full.no_ovf", {7'd0, overflow}, 8'd0);
    drain("full.drain");

    // Asynchronous reset in DATA bit 3 with two bytes queued.
    for (int i = 0; i < 3; i++) tick(1, 8'hC0 + 8'(i), "arst.push");
    guard = 0;
    while (!(m_infl && (FRAME - m_rem) / N == 4) && guard < 100) begin
      tick(0, 8'h00, "arst.wait");
      guard++;
    end
    check("arst.queued", {5'd0, fifo_count}, 8'd2);
    #2 reset = 1'b1;
    #1;
    check("arst.tx", {7'd0, tx}, 8'd1);
    check("arst.busy", {7'd0, busy}, 8'd0);
    check("arst.count", {5'd0, fifo_count}, 8'd0);
    m_reset();
    tick(0, 8'h00, "arst.hold");
    #2 reset = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) tick(0, 8'h00, "arst.quiet");

    // Pointer wrap: nine random bytes, one per frame.
    for (int i = 0; i < 9; i++) begin
      d = 8'($urandom_range(0, 255));
      tick(1, d, "wrap.push");
      drain("wrap.frame");
    end

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick(($urandom_range(0, 99) < 4), 8'($urandom_range(0, 255)), "rand");
      if (i == 1500) begin
        do_reset();
      end
    end
    for (int i = 0; i < 8; i++) tick(1, 8'($urandom_range(0, 255)), "rand.burst");
    drain("rand.drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
